t02_bus_bridge: RTL and testbench
=================================

T02_BUS_BRIDGE -- requirements
Module: t02_bus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, range 1..255: maximum REQ cycles awaiting ack before abort.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ren_i  input  1  core read request; held until busy_o falls.
REQ-005 wen_i  input  1  core write request; held until busy_o falls.
REQ-006 addr_i  input  32  core byte address.
REQ-007 wdata_i  input  32  core store data.
REQ-008 rdata_o  output  32  last completed read data.
REQ-009 busy_o  output  1  transaction pending; core holds request while high.
REQ-010 err_o  output  1  last transaction timed out.
REQ-011 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone classic manager controls.
REQ-012 wb_adr_o  output  32; wb_dat_o  output  32; wb_sel_o  output  4, constant 4'hF.
REQ-013 wb_dat_i  input  32; wb_ack_i  input  1  subordinate read data and acknowledge.

Function
REQ-014 FSM states IDLE, REQ, DONE only; default transition to IDLE.
REQ-015 IDLE: busy_o = ren_i | wen_i (combinational), otherwise 0.
REQ-016 IDLE with ren_i|wen_i at an edge: latch addr_i, wdata_i, we=wen_i into wb_adr_o/wb_dat_o/wb_we_o; set wb_cyc_o=wb_stb_o=1; clear err_o; go REQ.
REQ-017 ren_i and wen_i both high: write wins; no read issued.
REQ-018 REQ: busy_o=1; wb_cyc_o/wb_stb_o/wb_adr_o/wb_dat_o/wb_we_o stable; core inputs ignored.
REQ-019 REQ with wb_ack_i=1 at an edge: drop wb_cyc_o/wb_stb_o; on read, rdata_o <= wb_dat_i; go DONE.
REQ-020 Writes never alter rdata_o; rdata_o holds its value until the next completed read.
REQ-021 DONE: busy_o=0 for exactly one cycle; requests ignored; next state IDLE.
REQ-022 Minimum latency: request cycle + 1 REQ cycle (ack immediate) -> busy_o low 2 cycles after request first seen.
REQ-023 wb_ack_i outside REQ ignored; no state or data change.
REQ-024 Back-to-back: a request held through DONE is accepted in the following IDLE cycle.

Reset
REQ-025 rst=1 at an edge: state IDLE; rdata_o=0, err_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, timeout count 0.
REQ-026 rst mid-REQ: bus controls drop at that edge; any later ack ignored; no rdata_o update.

Configuration
REQ-027 Macro T02_BRIDGE_TIMEOUT_EN defined: counter counts REQ cycles; at TIMEOUT_CYCLES without ack, drop cyc/stb, set err_o=1, rdata_o <= 32'hDEAD_BEEF on reads (writes leave it), go DONE.
REQ-028 Ack and timeout on the same edge: ack wins; err_o stays 0.
REQ-029 Macro undefined: no counter logic; REQ waits indefinitely; err_o tied 0.

Structure
REQ-030 Package t02_bridge_pkg holds state enum, default TIMEOUT_CYCLES, error pattern 32'hDEAD_BEEF, sel constant 4'hF.
REQ-031 Sub-module t02_bridge_timer (8-bit clear/enable/expire counter) instantiated only under T02_BRIDGE_TIMEOUT_EN.

Verification
REQ-032 Read addr 0x0000_0040, ack after 3 REQ cycles with 0x1234_5678 -> wb_we_o=0, rdata_o=0x1234_5678, busy_o low for 1 cycle in DONE.
REQ-033 Write 0xCAFE_F00D to 0x0000_0080, ack immediate -> wb_we_o=1, wb_dat_o=0xCAFE_F00D, rdata_o unchanged, busy_o low 2 cycles after request.
REQ-034 ren_i=wen_i=1 -> single write cycle only; exactly one cyc/stb assertion.
REQ-035 rst pulsed during REQ, ack one cycle later -> cyc/stb 0 after reset edge, rdata_o=0, state IDLE.
REQ-036 Timeout enabled, TIMEOUT_CYCLES=4, no ack on read -> cyc/stb drop after 4 REQ cycles, err_o=1, rdata_o=0xDEAD_BEEF; next request clears err_o.
REQ-037 Held read request through DONE -> second transaction starts the cycle after DONE; stray ack in DONE ignored.

Source files
------------

// File: rtl/t02_bridge_pkg.sv
// rtl/t02_bridge_pkg.sv - shared types and constants for the t02 core-to-Wishbone bridge
package t02_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DEFAULT_TIMEOUT_CYCLES = 16;
    localparam logic [31:0] ERR_PATTERN            = 32'hDEAD_BEEF;
    localparam logic [3:0]  WB_SEL_ALL             = 4'hF;

endpackage

// File: rtl/t02_bridge_timer.sv
// rtl/t02_bridge_timer.sv - 8-bit clear/enable counter that flags the last allowed cycle
module t02_bridge_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count_q;

    // expire is combinational so the owner can act on the same edge that ends cycle LIMIT
    assign expire = enable && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= 8'd0;
        end else if (enable && !expire) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/t02_bus_bridge.sv
// rtl/t02_bus_bridge.sv - single-outstanding core to Wishbone classic bridge; optional timeout via T02_BRIDGE_TIMEOUT_EN
module t02_bus_bridge
    import t02_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren_i,
    input  logic        wen_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    state_t state_q, state_d;
    logic   req;
    logic   timeout_hit;

    assign req      = ren_i | wen_i;
    assign wb_sel_o = WB_SEL_ALL;

`ifdef T02_BRIDGE_TIMEOUT_EN
    logic err_q;

    t02_bridge_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != REQ),
        .enable (state_q == REQ),
        .expire (timeout_hit)
    );

    // an ack on the expiry edge completes normally, so err only sets without ack
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && req) begin
            err_q <= 1'b0;
        end else if (state_q == REQ && !wb_ack_i && timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_cfg;

    assign unused_cfg  = (TIMEOUT_CYCLES != 0);
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = req;
                if (req) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                busy_o = 1'b1;
                if (wb_ack_i || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= 32'd0;
            wb_dat_o <= 32'd0;
            rdata_o  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wb_adr_o <= addr_i;
                        wb_dat_o <= wdata_i;
                        wb_we_o  <= wen_i;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (!wb_we_o) begin
                            rdata_o <= wb_dat_i;
                        end
                    end else if (timeout_hit) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (!wb_we_o) begin
                            rdata_o <= ERR_PATTERN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_t02_bus_bridge.sv
// tb/tb_t02_bus_bridge.sv - directed self-checking bench for t02_bus_bridge
module tb_t02_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ren_i = 1'b0;
    logic        wen_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic        wb_ack_i = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc_starts = 0;
    logic cyc_prev = 1'b0;
    int starts_before;

    t02_bus_bridge #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ren_i    (ren_i),
        .wen_i    (wen_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .busy_o   (busy_o),
        .err_o    (err_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wb_cyc_o && !cyc_prev) cyc_starts++;
        cyc_prev = wb_cyc_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        check("rst_cyc",   32'(wb_cyc_o), 32'd0);
        check("rst_stb",   32'(wb_stb_o), 32'd0);
        check("rst_we",    32'(wb_we_o),  32'd0);
        check("rst_adr",   wb_adr_o,      32'd0);
        check("rst_dat",   wb_dat_o,      32'd0);
        check("rst_rdata", rdata_o,       32'd0);
        check("rst_err",   32'(err_o),    32'd0);
        check("rst_busy",  32'(busy_o),   32'd0);
        check("sel_const", 32'(wb_sel_o), 32'hF);
        rst = 1'b0;
        step();

        // read with ack in the third REQ cycle
        ren_i = 1'b1; addr_i = 32'h0000_0040;
        #1;
        check("rd_busy_idle", 32'(busy_o), 32'd1);
        step();
        check("rd_cyc",  32'(wb_cyc_o), 32'd1);
        check("rd_stb",  32'(wb_stb_o), 32'd1);
        check("rd_we",   32'(wb_we_o),  32'd0);
        check("rd_adr",  wb_adr_o,      32'h0000_0040);
        addr_i = 32'hFFFF_FFFF;
        step();
        step();
        check("rd_hold_cyc", 32'(wb_cyc_o), 32'd1);
        check("rd_hold_adr", wb_adr_o,      32'h0000_0040);
        check("rd_hold_busy", 32'(busy_o),  32'd1);
        wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
        step();
        check("rd_done_busy",  32'(busy_o),   32'd0);
        check("rd_done_cyc",   32'(wb_cyc_o), 32'd0);
        check("rd_done_rdata", rdata_o,       32'h1234_5678);
        wb_ack_i = 1'b0; ren_i = 1'b0;
        step();
        check("rd_idle_busy", 32'(busy_o), 32'd0);

        // write with immediate ack leaves rdata alone
        wen_i = 1'b1; addr_i = 32'h0000_0080; wdata_i = 32'hCAFE_F00D;
        step();
        check("wr_we",  32'(wb_we_o), 32'd1);
        check("wr_dat", wb_dat_o,     32'hCAFE_F00D);
        check("wr_adr", wb_adr_o,     32'h0000_0080);
        check("wr_busy", 32'(busy_o), 32'd1);
        wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_0000;
        step();
        check("wr_done_busy",  32'(busy_o),   32'd0);
        check("wr_done_cyc",   32'(wb_cyc_o), 32'd0);
        check("wr_rdata_kept", rdata_o,       32'h1234_5678);
        wb_ack_i = 1'b0; wen_i = 1'b0;
        step();

        // simultaneous read and write: one write cycle only
        starts_before = cyc_starts;
        ren_i = 1'b1; wen_i = 1'b1; addr_i = 32'h0000_0100; wdata_i = 32'h55AA_55AA;
        step();
        check("both_we",  32'(wb_we_o), 32'd1);
        check("both_dat", wb_dat_o,     32'h55AA_55AA);
        wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
        step();
        ren_i = 1'b0; wen_i = 1'b0; wb_ack_i = 1'b0;
        step();
        step();
        step();
        check("both_rdata_kept", rdata_o, 32'h1234_5678);
        check("both_one_cycle",  32'(cyc_starts - starts_before), 32'd1);

        // reset in the middle of a read, then a stray ack
        ren_i = 1'b1; addr_i = 32'h0000_0200;
        step();
        check("rstmid_cyc_pre", 32'(wb_cyc_o), 32'd1);
        rst = 1'b1; ren_i = 1'b0;
        step();
        check("rstmid_cyc", 32'(wb_cyc_o), 32'd0);
        check("rstmid_stb", 32'(wb_stb_o), 32'd0);
        rst = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h9999_9999;
        step();
        check("rstmid_rdata", rdata_o,       32'd0);
        check("rstmid_cyc2",  32'(wb_cyc_o), 32'd0);
        check("rstmid_busy",  32'(busy_o),   32'd0);
        check("rstmid_adr",   wb_adr_o,      32'd0);
        wb_ack_i = 1'b0;
        step();

        // held read through DONE, stray ack in DONE
        ren_i = 1'b1; addr_i = 32'h0000_0300;
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
        step();
        check("b2b_done_busy",  32'(busy_o), 32'd0);
        check("b2b_done_rdata", rdata_o,     32'h0BAD_F00D);
        addr_i = 32'h0000_0304; wb_dat_i = 32'h1111_1111;
        step();
        check("b2b_stray_rdata", rdata_o,       32'h0BAD_F00D);
        check("b2b_idle_cyc",    32'(wb_cyc_o), 32'd0);
        check("b2b_idle_busy",   32'(busy_o),   32'd1);
        wb_ack_i = 1'b0;
        step();
        check("b2b_second_cyc", 32'(wb_cyc_o), 32'd1);
        check("b2b_second_adr", wb_adr_o,      32'h0000_0304);
        wb_ack_i = 1'b1; wb_dat_i = 32'h2222_2222;
        step();
        check("b2b_second_rdata", rdata_o, 32'h2222_2222);
        ren_i = 1'b0; wb_ack_i = 1'b0;
        step();

`ifdef T02_BRIDGE_TIMEOUT_EN
        // read with no ack times out after four REQ cycles
        ren_i = 1'b1; addr_i = 32'h0000_0400;
        step();
        step();
        step();
        step();
        check("to_cyc_before", 32'(wb_cyc_o), 32'd1);
        check("to_err_before", 32'(err_o),    32'd0);
        step();
        check("to_cyc",   32'(wb_cyc_o), 32'd0);
        check("to_stb",   32'(wb_stb_o), 32'd0);
        check("to_err",   32'(err_o),    32'd1);
        check("to_rdata", rdata_o,       32'hDEAD_BEEF);
        check("to_busy",  32'(busy_o),   32'd0);
        ren_i = 1'b0;
        step();
        check("to_err_held", 32'(err_o), 32'd1);
        wen_i = 1'b1; addr_i = 32'h0000_0404;
        step();
        check("to_err_cleared", 32'(err_o), 32'd0);
        wb_ack_i = 1'b1;
        step();
        wen_i = 1'b0; wb_ack_i = 1'b0;
        step();

        // ack on the expiry edge wins
        ren_i = 1'b1; addr_i = 32'h0000_0408;
        step();
        step();
        step();
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'h3333_3333;
        step();
        check("race_err",   32'(err_o), 32'd0);
        check("race_rdata", rdata_o,    32'h3333_3333);
        ren_i = 1'b0; wb_ack_i = 1'b0;
        step();
`else
        // without the timeout feature a read waits indefinitely
        ren_i = 1'b1; addr_i = 32'h0000_0500;
        step();
        ren_i = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("wait_cyc",  32'(wb_cyc_o), 32'd1);
        check("wait_busy", 32'(busy_o),   32'd1);
        check("wait_err",  32'(err_o),    32'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h4444_4444;
        step();
        check("wait_rdata", rdata_o, 32'h4444_4444);
        wb_ack_i = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
